// File: rtl/random_sequencer.sv
// Round-robin sequencer for the shared serial random core: seed load, warm-up discard, WIDTH-bit deserialise.
// Optional reserved-code rejection is enabled with `define RANDOM_SEQ_CODE_CHECK_EN.
module random_sequencer #(
   parameter int WIDTH  = 8,
   parameter int WARMUP = 2
) (
   input  logic             Cp,
   input  logic             Rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [2:0]       code0,
   input  logic [2:0]       code1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             S,
   output logic [2:0]       code,
   input  logic             rnd_in,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   output logic             rid,
   output logic             rerr
);

   typedef enum logic [2:0] {IDLE, LOAD, WARM, SHIFT, DONE} state_t;

   localparam logic [5:0] WARM_LAST  = 6'(WARMUP - 1);
   localparam logic [5:0] WIDTH_LAST = 6'(WIDTH - 1);

   state_t           state_r, state_nxt;
   logic [5:0]       cnt_r, cnt_nxt;
   logic [WIDTH-1:0] sh_r, sh_nxt;
   logic [WIDTH-1:0] rdata_r, rdata_nxt;
   logic [2:0]       code_r, code_nxt;
   logic             ptr_r, ptr_nxt;
   logic             id_r, id_nxt;
   logic             rid_r, rid_nxt;
   logic             gnt0_r, gnt0_nxt;
   logic             gnt1_r, gnt1_nxt;
   logic             take0_s, take1_s;
   logic [2:0]       sel_code_s;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
   logic             err_r, err_nxt;
`endif

   // Arbitration: the pointer only matters when both requesters are asking
   always_comb begin
      take0_s    = req0 & (~req1 | ~ptr_r);
      take1_s    = req1 & (~req0 | ptr_r);
      sel_code_s = take1_s ? code1 : code0;
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      sh_nxt    = sh_r;
      rdata_nxt = rdata_r;
      code_nxt  = code_r;
      ptr_nxt   = ptr_r;
      id_nxt    = id_r;
      rid_nxt   = rid_r;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
      err_nxt   = err_r;
`endif
      case (state_r)
         IDLE: begin
            if (take0_s | take1_s) begin
               gnt0_nxt = take0_s;
               gnt1_nxt = take1_s;
               ptr_nxt  = take0_s;
               id_nxt   = take1_s;
               cnt_nxt  = 6'd0;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
               if (sel_code_s == 3'b111) begin
                  // Reserved code: report at once, never touch the core
                  state_nxt = DONE;
                  rdata_nxt = '0;
                  rid_nxt   = take1_s;
                  err_nxt   = 1'b1;
               end else begin
                  state_nxt = LOAD;
                  code_nxt  = sel_code_s;
                  err_nxt   = 1'b0;
               end
`else
               state_nxt = LOAD;
               code_nxt  = sel_code_s;
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            cnt_nxt = 6'd0;
            if (WARMUP == 0) begin
               state_nxt = SHIFT;
            end else begin
               state_nxt = WARM;
            end
         end
         WARM: begin
            if (cnt_r == WARM_LAST) begin
               state_nxt = SHIFT;
               cnt_nxt   = 6'd0;
            end else begin
               cnt_nxt = cnt_r + 6'd1;
            end
         end
         SHIFT: begin
            sh_nxt = (sh_r << 1) | {{(WIDTH-1){1'b0}}, rnd_in};
            if (cnt_r == WIDTH_LAST) begin
               state_nxt = DONE;
               rdata_nxt = sh_nxt;
               rid_nxt   = id_r;
            end else begin
               cnt_nxt = cnt_r + 6'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge Cp or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Datapath and output registers
   always_ff @(posedge Cp or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_r   <= 6'd0;
         sh_r    <= '0;
         rdata_r <= '0;
         code_r  <= 3'b000;
         ptr_r   <= 1'b0;
         id_r    <= 1'b0;
         rid_r   <= 1'b0;
         gnt0_r  <= 1'b0;
         gnt1_r  <= 1'b0;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
         err_r   <= 1'b0;
`endif
      end else begin
         cnt_r   <= cnt_nxt;
         sh_r    <= sh_nxt;
         rdata_r <= rdata_nxt;
         code_r  <= code_nxt;
         ptr_r   <= ptr_nxt;
         id_r    <= id_nxt;
         rid_r   <= rid_nxt;
         gnt0_r  <= gnt0_nxt;
         gnt1_r  <= gnt1_nxt;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
         err_r   <= err_nxt;
`endif
      end
   end

   assign gnt0   = gnt0_r;
   assign gnt1   = gnt1_r;
   assign S      = (state_r == LOAD);
   assign code   = code_r;
   assign rdata  = rdata_r;
   assign rvalid = (state_r == DONE);
   assign rid    = rid_r;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
   assign rerr   = err_r & (state_r == DONE);
`else
   assign rerr   = 1'b0;
`endif

endmodule

// File: tb/tb_random_sequencer.sv
// Scoreboard bench for random_sequencer (WIDTH=8, WARMUP=2): directed transactions, arbitration, reset abort.
module tb_random_sequencer;

   logic       Cp, Rst_n;
   logic       req0, req1;
   logic [2:0] code0, code1;
   logic       gnt0, gnt1, S;
   logic [2:0] code;
   logic       rnd_in;
   logic [7:0] rdata;
   logic       rvalid, rid, rerr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic [7:0] rdata;
      logic       rid;
      logic       rerr;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   random_sequencer #(.WIDTH(8), .WARMUP(2)) dut (
      .Cp(Cp), .Rst_n(Rst_n), .req0(req0), .req1(req1), .code0(code0), .code1(code1),
      .gnt0(gnt0), .gnt1(gnt1), .S(S), .code(code), .rnd_in(rnd_in),
      .rdata(rdata), .rvalid(rvalid), .rid(rid), .rerr(rerr)
   );

   initial begin
      Cp = 1'b0;
      forever #5 Cp = ~Cp;
   end

   always @(posedge Cp) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
      chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
      chk({tag, "_S"}, 32'(S), 32'd0);
      chk({tag, "_code"}, 32'(code), 32'd0);
      chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
      chk({tag, "_rdata"}, 32'(rdata), 32'd0);
      chk({tag, "_rid"}, 32'(rid), 32'd0);
      chk({tag, "_rerr"}, 32'(rerr), 32'd0);
   endtask

   task automatic tick();
      @(posedge Cp);
      #1;
   endtask

   // Monitor: every rvalid must match the oldest expected result, including its cycle
   always @(negedge Cp) begin : monitor
      exp_t e;
      if (rvalid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("res_cycle", 32'(cyc), 32'(e.cyc));
            chk("res_rdata", 32'(rdata), 32'(e.rdata));
            chk("res_rid", 32'(rid), 32'(e.rid));
            chk("res_rerr", 32'(rerr), 32'(e.rerr));
         end
      end
   end

   // Called during cycle 0 with the request already presented; returns in cycle 13
   task automatic run_txn(input logic who, input logic [2:0] exp_code, input logic [7:0] bits,
                          input bit drop, input bit raise1);
      int a;
      a = cyc;
      sb.push_back('{rdata: bits, rid: who, rerr: 1'b0, cyc: a + 12});
      tick();
      chk("c1_gnt0", 32'(gnt0), 32'(!who));
      chk("c1_gnt1", 32'(gnt1), 32'(who));
      chk("c1_S", 32'(S), 32'd1);
      chk("c1_code", 32'(code), 32'(exp_code));
      if (drop) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      tick();
      chk("c2_gnt0", 32'(gnt0), 32'd0);
      chk("c2_gnt1", 32'(gnt1), 32'd0);
      chk("c2_S", 32'(S), 32'd0);
      tick();
      rnd_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         rnd_in = bits[7-k];
         if (raise1 && k == 1) req1 = 1'b1;
      end
      tick();
      chk("c12_code_held", 32'(code), 32'(exp_code));
      tick();
   endtask

   initial begin
      Rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      code0 = 3'b000; code1 = 3'b000;
      rnd_in = 1'b0;
      #1;
      chk_zero("por");
      @(negedge Cp); Rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_gnt0", 32'(gnt0), 32'd0);
         chk("idle_S", 32'(S), 32'd0);
      end
      @(negedge Cp); Rst_n = 1'b0;
      #1;
      chk_zero("idle_rst");
      @(negedge Cp); Rst_n = 1'b1;
      tick();

      // Single transaction: bits 1,0,1,1,0,0,1,0 -> 8'hB2
      req0 = 1'b1; code0 = 3'b010;
      run_txn(1'b0, 3'b010, 8'hB2, 1'b1, 1'b0);

      // Both held from reset: strict alternation starting with req0
      @(negedge Cp); Rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1; code0 = 3'b011; code1 = 3'b101;
      @(negedge Cp); Rst_n = 1'b1;
      run_txn(1'b0, 3'b011, 8'h5A, 1'b0, 1'b0);
      run_txn(1'b1, 3'b101, 8'hC3, 1'b0, 1'b0);
      run_txn(1'b0, 3'b011, 8'h0F, 1'b0, 1'b0);
      run_txn(1'b1, 3'b101, 8'hF0, 1'b1, 1'b0);

      // req1 rising mid-transaction waits for IDLE
      req0 = 1'b1; code0 = 3'b001; code1 = 3'b110;
      run_txn(1'b0, 3'b001, 8'h81, 1'b1, 1'b1);
      run_txn(1'b1, 3'b110, 8'h3C, 1'b1, 1'b0);

      // Reset during SHIFT aborts; held req0 is re-accepted afterwards
      req0 = 1'b1; code0 = 3'b100;
      tick();
      chk("abort_gnt0", 32'(gnt0), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      Rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      @(negedge Cp); Rst_n = 1'b1;
      run_txn(1'b0, 3'b100, 8'h99, 1'b1, 1'b0);

      // Reserved code 3'b111
      req0 = 1'b1; code0 = 3'b111;
`ifdef RANDOM_SEQ_CODE_CHECK_EN
      sb.push_back('{rdata: 8'h00, rid: 1'b0, rerr: 1'b1, cyc: cyc + 1});
      tick();
      chk("inv_gnt0", 32'(gnt0), 32'd1);
      chk("inv_S", 32'(S), 32'd0);
      chk("inv_code", 32'(code), 32'(3'b100));
      req0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("inv_S_after", 32'(S), 32'd0);
      end
`else
      run_txn(1'b0, 3'b111, 8'hA5, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 4; i++) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/random_sequencer.md
# random_sequencer

Controller that sequences the shared serial random-number core (`random`) between two requesters. It arbitrates round-robin, drives the core's seed-load strobe and 3-bit code, and discards a fixed number of warm-up bits. It then deserialises the core's 1-bit output into a WIDTH-bit word, returned with a one-cycle valid pulse tagged with the requester ID. It sits between the core and the logic consuming random words.

## Interface
- WIDTH, 8, bits collected per transaction (2..32)
- WARMUP, 2, core output bits discarded after seed load (0..15)

- Cp  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  level request; held until matching gnt
- code0 / code1  in  3  code for that requester; sampled at acceptance edge
- gnt0 / gnt1  out  1  one-cycle registered grant pulse
- S  out  1  seed-load strobe to core
- code  out  3  code to core; latched per transaction
- rnd_in  in  1  serial output of core
- rdata  out  WIDTH  collected word; held until next DONE
- rvalid  out  1  one-cycle result pulse
- rid  out  1  requester of rdata (0/1)
- rerr  out  1  invalid-code flag; valid with rvalid

## Operation
- Single clock; Rst_n is asynchronous and active-low; Cp is the only clock.
- FSM states: IDLE, LOAD, WARM, SHIFT, DONE.
- IDLE: if any req is high at a rising edge, accept one. Round-robin pointer favours req0 after reset. After a grant, priority passes to the other requester. Latch its code and ID, then go to LOAD.
  - With WARMUP=0, go LOAD→SHIFT.
  - With the invalid-code check (see Configuration), go directly to DONE.
- LOAD: S=1 for exactly this cycle.
- WARM: WARMUP cycles; rnd_in ignored.
- SHIFT: WIDTH cycles.
  - Each closing edge samples rnd_in into the shift register.
  - Shift is left, first bit lands in MSB.
- DONE: rvalid=1, rid=latched ID, rdata=collected word; next state IDLE.
- Arbitration and request handling:
  - Requests seen outside IDLE are ignored until IDLE; no queueing.
  - A requester dropping req before gnt withdraws cleanly.
  - Simultaneous req0 and req1 are resolved by the pointer only.
- Output decoding:
  - All outputs are registered or decoded from registered state only; no combinational input→output path.
  - code output holds the last latched code between transactions.
- Reset, asynchronous, any state:
  - state=IDLE, S=0, code=000, gnt0=gnt1=0, rvalid=0, rerr=0, rdata=0, rid=0, pointer→req0.
  - A transaction in flight is aborted with no rvalid.

## Timing
- Acceptance edge = edge 0.
- LOAD in cycle 1; gnt pulses in cycle 1.
- WARM in cycles 2..WARMUP+1.
- SHIFT in cycles WARMUP+2..WARMUP+WIDTH+1.
- DONE/rvalid in cycle WARMUP+WIDTH+2.
- IDLE in cycle WARMUP+WIDTH+3; the earliest next acceptance is at that cycle's closing edge.
- Throughput: one word per WIDTH+WARMUP+3 cycles.
- Core samples S at the edge closing LOAD; its first valid bit appears after that edge.

## Configuration
- RANDOM_SEQ_CODE_CHECK_EN defined:
  - Code 3'b111 is reserved. The request is accepted and gnt pulses in cycle 1, with state=DONE.
  - rvalid=1, rerr=1 and rdata=0 in cycle 1.
  - S is never asserted and the code output is not updated.
- Undefined: 3'b111 runs a normal transaction; rerr is tied to 0.

## Test plan
- Reset, then a reset pulse mid-idle:
  - All outputs 0 while Rst_n=0 (checked without a clock edge).
  - Nothing happens with req low after release.
- req0=1, code0=3'b010, WIDTH=8, WARMUP=2; rnd_in=1,0,1,1,0,0,1,0 across SHIFT cycles 4..11:
  - gnt0 and S in cycle 1 only; code=010 from cycle 1.
  - rvalid in cycle 12, rdata=8'hB2, rid=0, rerr=0.
- req0 and req1 both held continuously from reset:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - rid sequence 0,1,0,1; acceptances 13 cycles apart.
- req1 rises in cycle 5 of a req0 transaction:
  - Ignored until IDLE; accepted at the edge closing cycle 13; gnt1 in cycle 14.
- Rst_n low in cycle 6 of a transaction (SHIFT):
  - Immediate reset values; no rvalid.
  - After release, the still-held req0 is re-accepted and completes normally.
- code0=3'b111:
  - With RANDOM_SEQ_CODE_CHECK_EN: gnt0, rvalid, rerr=1, rdata=0 in cycle 1; S stays 0.
  - Without it: normal 12-cycle transaction, rerr=0.
